// File: rtl/npu_sram_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port SRAM among NREQ NPU engines.
// Whole bursts are granted; the owner's beats issue back-to-back with incrementing addresses.

module npu_sram_port_lane #(
  parameter int OW = 2,
  parameter int ID = 0
) (
  input  logic          busy_i,
  input  logic [OW-1:0] owner_i,
  input  logic          last_i,
  input  logic          rd_pend_i,
  input  logic [OW-1:0] rd_owner_i,
  output logic          ack_o,
  output logic          ack_last_o,
  output logic          rvalid_o
);
  localparam logic [OW-1:0] MY_ID = OW'(ID);

  assign ack_o      = busy_i && (owner_i == MY_ID);
  assign ack_last_o = ack_o && last_i;
  assign rvalid_o   = rd_pend_i && (rd_owner_i == MY_ID);
endmodule

module npu_sram_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*LEN_W-1:0]    req_len,
  input  logic [NREQ*BE_W-1:0]     req_byteenable,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          ack_last,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        sram_address,
  output logic [BE_W-1:0]          sram_byteenable,
  output logic                     sram_chipselect,
  output logic                     sram_write,
  output logic [DATA_W-1:0]        sram_writedata,
  input  logic [DATA_W-1:0]        sram_readdata
);
  localparam int OW = $clog2(NREQ);
  localparam logic [OW-1:0] LAST_ID = OW'(NREQ - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q;
  logic [OW-1:0]     owner_q, ptr_q, rd_owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [BE_W-1:0]   be_q;
  logic              write_q, rd_pend_q;

  logic [NREQ-1:0][ADDR_W-1:0] addr_a;
  logic [NREQ-1:0][LEN_W-1:0]  len_a;
  logic [NREQ-1:0][BE_W-1:0]   be_a;
  logic [NREQ-1:0][DATA_W-1:0] wdata_a;

  assign addr_a  = req_addr;
  assign len_a   = req_len;
  assign be_a    = req_byteenable;
  assign wdata_a = req_wdata;

  // Rotating priority: first set request at or after ptr_q wins.
  logic          win_vld;
  logic [OW-1:0] win;
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = OW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      be_q       <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      rd_pend_q  <= (state_q == BURST) && !write_q;
      rd_owner_q <= owner_q;
      case (state_q)
        IDLE: if (win_vld) begin
          owner_q <= win;
          addr_q  <= addr_a[win];
          cnt_q   <= len_a[win];
          write_q <= req_write[win];
          be_q    <= be_a[win];
          state_q <= BURST;
        end
        BURST: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= IDLE;
            ptr_q   <= (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = (state_q == BURST);
  assign sram_chipselect = busy;
  assign sram_address    = busy ? addr_q : '0;
  assign sram_write      = busy && write_q;
  assign sram_byteenable = busy ? (write_q ? be_q : '1) : '0;
  assign sram_writedata  = busy ? wdata_a[owner_q] : '0;
  assign rdata           = sram_readdata;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    npu_sram_port_lane #(.OW(OW), .ID(i)) u_lane (
      .busy_i     (busy),
      .owner_i    (owner_q),
      .last_i     (cnt_q == '0),
      .rd_pend_i  (rd_pend_q),
      .rd_owner_i (rd_owner_q),
      .ack_o      (ack[i]),
      .ack_last_o (ack_last[i]),
      .rvalid_o   (rvalid[i])
    );
  end
endmodule

// File: doc/npu_sram_port_arbiter.md
# npu_sram_port_arbiter

Round-robin burst arbiter sharing one port of a 4096×16 byte-enabled on-chip SRAM (registered address/data, unregistered read output, 1-cycle read latency) among NREQ NPU requesters, e.g. weight loader, activation fetch and result writeback. It grants whole bursts, generates incrementing addresses, steers write data and byte enables from the owner, and routes returned read data back with a per-requester valid strobe. It sits between the NPU datapath engines and the SRAM port signals `address`, `byteenable`, `chipselect`, `write`, `writedata` and `readdata`.

## Interface
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 12, SRAM word address width
- DATA_W, 16, SRAM data width
- BE_W, 2, byte-enable width (DATA_W/8)
- LEN_W, 8, burst length field width; beats = len+1
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request, sampled only in IDLE
- req_write  in  NREQ  1 = write burst, 0 = read burst
- req_addr  in  NREQ*ADDR_W  burst start address, slice i for requester i
- req_len  in  NREQ*LEN_W  beats minus one
- req_byteenable  in  NREQ*BE_W  write byte enables, held for the whole burst
- req_wdata  in  NREQ*DATA_W  current write beat data
- ack  out  NREQ  combinational; beat of requester i issued this cycle
- ack_last  out  NREQ  combinational; last beat of the burst issued this cycle
- rvalid  out  NREQ  registered; rdata valid for requester i
- rdata  out  DATA_W  equals sram_readdata
- busy  out  1  state == BURST
- sram_address  out  ADDR_W  SRAM port address
- sram_byteenable  out  BE_W  SRAM port byte enables
- sram_chipselect  out  1  SRAM port chip select
- sram_write  out  1  SRAM port write
- sram_writedata  out  DATA_W  SRAM port write data
- sram_readdata  in  DATA_W  SRAM port read data, valid 1 cycle after a read beat

## Operation
- Registers: state {IDLE, BURST}, owner, ptr (round-robin pointer), addr_q, cnt_q, write_q, be_q, rd_pend_q, rd_owner_q.
- IDLE: if any req, the winner is the first set bit searching ptr, ptr+1, … mod NREQ. At the edge, latch owner, addr_q=req_addr[win], cnt_q=req_len[win], write_q, be_q, and go to BURST. If no req, stay.
- BURST: one beat per cycle, no stalls.
  - sram_chipselect=1, sram_address=addr_q, sram_write=write_q.
  - sram_byteenable=be_q on writes, all ones on reads.
  - sram_writedata=req_wdata[owner]; ack[owner]=1.
  - Each edge: addr_q = addr_q+1 mod 2^ADDR_W, wrapping 4095→0. cnt_q decrements.
  - When cnt_q==0, ack_last[owner]=1. At that edge go to IDLE and set ptr=(owner+1) mod NREQ.
- Outside BURST, all sram_* outputs, ack and ack_last are 0.
- Requester protocol:
  - Hold req and the burst fields stable until the first ack.
  - Advance req_wdata at each edge where ack is high.
  - Deassert req at the edge where ack_last is high. A req still high in IDLE is a new request.
- Read return: rd_pend_q <= BURST & ~write_q; rd_owner_q <= owner. rvalid[i] = rd_pend_q & (rd_owner_q==i).
- Reset values: state=IDLE, ptr=0, owner=0, addr_q=0, cnt_q=0, rd_pend_q=0. All outputs are 0, and rdata follows sram_readdata.
- Reset mid-burst: abort immediately with no further beats. Any pending rvalid is dropped.

## Timing
- req seen high in IDLE at cycle N → first beat (ack, chipselect) in cycle N+1.
- A burst of len L occupies cycles N+1..N+L+1, and IDLE follows in cycle N+L+2.
- Minimum turnaround between grants is one IDLE arbitration cycle. Peak utilisation is (L+1)/(L+2).
- Read beat issued in cycle k → rvalid[owner] and rdata in cycle k+1. The last read beat's rvalid falls in the IDLE cycle.
- Requests arriving during BURST wait. Worst-case wait is NREQ−1 maximal bursts plus bubbles.

## Test plan
- Single read: req[0], addr 0x010, len 0, SRAM preloaded 0x010=0xBEEF. Required: ack[0] and ack_last[0] in cycle 1, sram_address=0x010; rvalid[0] with rdata=0xBEEF in cycle 2; busy low from cycle 2.
- Wrapping write burst: req[1], addr 0xFFE, len 3, data 0x1111..0x4444, byteenable 2'b11. Required: addresses 0xFFE, 0xFFF, 0x000, 0x001; readback via req[2] returns the same four words.
- Byte enables: write 0xAABB with byteenable 2'b01 over 0x1234 at 0x020. Required: read returns 0x12BB; the read burst drives sram_byteenable=2'b11.
- Contention: req[0..2] high together from reset, each len 1. Required: grant order 0,1,2 with a one-cycle IDLE between bursts, then ptr=0. Raising only req[1] and req[2] afterwards grants 1 then 2.
- Reset mid-burst: read len 7 from requester 2, reset_n low after beat 3. Required: chipselect, ack and rvalid go 0 asynchronously; after release the block is IDLE, ptr=0, and a new req[2] is granted normally.
- Back-to-back: requester 0 holds req through ack_last with req[1] idle. Required: a second burst starts after exactly one IDLE cycle.
